// File: rtl/pwm_capture.sv
// ============================================================================
//  Module      : pwm_capture
//  Description : APB3 slave that measures the period and high time of up to
//                NUM_CH PWM waveforms in PCLK cycles. Each new capture sets a
//                VALID flag and can raise a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_capture #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 24
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic [7:0]        PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [NUM_CH-1:0] PWM_IN,
    output logic              IRQ
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Control and status
    logic [NUM_CH-1:0] en_q, en_d;
    logic [NUM_CH-1:0] irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] missed_q, missed_d;
    logic              irq_q, irq_d;

    // Input synchronizer chain (s3 is the edge-detect history flop)
    logic [NUM_CH-1:0] s1_q, s2_q, s3_q;

    // Per-channel measurement state
    logic [NUM_CH-1:0] armed_q, armed_d;
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  hi_lat_q [NUM_CH];
    logic [CNT_W-1:0]  hi_lat_d [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  high_q   [NUM_CH];
    logic [CNT_W-1:0]  high_d   [NUM_CH];

    // Combinational helpers
    logic              wr_en, wr_ctrl, wr_status;
    logic [NUM_CH-1:0] rise, fall;
    logic [NUM_CH-1:0] set_valid, set_ovf, set_missed;
    logic [NUM_CH-1:0] clr_valid, clr_ovf, clr_missed;
    logic              unused_bits;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign IRQ     = irq_q;

    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign wr_ctrl   = wr_en && (PADDR[7:2] == 6'h00);
    assign wr_status = wr_en && (PADDR[7:2] == 6'h01);

    assign clr_valid  = wr_status ? PWDATA[0  +: NUM_CH] : '0;
    assign clr_ovf    = wr_status ? PWDATA[8  +: NUM_CH] : '0;
    assign clr_missed = wr_status ? PWDATA[16 +: NUM_CH] : '0;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    // Byte-lane bits below word granularity and unused data bits are don't-care
    assign unused_bits = ^{PADDR[1:0], PWDATA};

    // Next-state: control register, counters, captures and sticky status
    always_comb begin
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        armed_d    = armed_q;
        set_valid  = '0;
        set_ovf    = '0;
        set_missed = '0;
        if (wr_ctrl) begin
            en_d     = PWDATA[0 +: NUM_CH];
            irq_en_d = PWDATA[8 +: NUM_CH];
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            cnt_d[ch]    = cnt_q[ch];
            hi_lat_d[ch] = hi_lat_q[ch];
            period_d[ch] = period_q[ch];
            high_d[ch]   = high_q[ch];
            if (!en_q[ch]) begin
                // Disabled: forget the partial measurement, keep results
                cnt_d[ch]    = '0;
                hi_lat_d[ch] = '0;
                armed_d[ch]  = 1'b0;
            end else begin
                if (rise[ch]) begin
                    cnt_d[ch] = CNT_ONE;
                    if (armed_q[ch]) begin
                        period_d[ch]   = cnt_q[ch];
                        high_d[ch]     = hi_lat_q[ch];
                        set_valid[ch]  = 1'b1;
                        set_missed[ch] = valid_q[ch];
                    end
                    armed_d[ch] = 1'b1;
                end else if (cnt_q[ch] != CNT_MAX) begin
                    cnt_d[ch] = cnt_q[ch] + CNT_ONE;
                    if (cnt_q[ch] == CNT_PRE) begin
                        // Counter saturates this cycle: measurement is void
                        set_ovf[ch] = 1'b1;
                        armed_d[ch] = 1'b0;
                    end
                end
                if (fall[ch]) begin
                    hi_lat_d[ch] = cnt_q[ch];
                end
            end
        end
        // A hardware set beats a simultaneous software clear
        valid_d  = (valid_q  & ~clr_valid)  | set_valid;
        ovf_d    = (ovf_q    & ~clr_ovf)    | set_ovf;
        missed_d = (missed_q & ~clr_missed) | set_missed;
        irq_d    = |(valid_q & irq_en_q);
    end

    // Read mux: combinational from the address during a read, zero otherwise
    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            if (PADDR[7:2] == 6'h00) begin
                PRDATA[0 +: NUM_CH] = en_q;
                PRDATA[8 +: NUM_CH] = irq_en_q;
            end else if (PADDR[7:2] == 6'h01) begin
                PRDATA[0  +: NUM_CH] = valid_q;
                PRDATA[8  +: NUM_CH] = ovf_q;
                PRDATA[16 +: NUM_CH] = missed_q;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (PADDR[7:2] == 6'(4 + 2 * ch)) begin
                    PRDATA = 32'(period_q[ch]);
                end
                if (PADDR[7:2] == 6'(5 + 2 * ch)) begin
                    PRDATA = 32'(high_q[ch]);
                end
            end
        end
    end

    // Two-flop synchronizer plus edge-detect history flop per channel
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= PWM_IN;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // State registers for control, status, interrupt and measurement
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            en_q     <= '0;
            irq_en_q <= '0;
            valid_q  <= '0;
            ovf_q    <= '0;
            missed_q <= '0;
            armed_q  <= '0;
            irq_q    <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]    <= '0;
                hi_lat_q[ch] <= '0;
                period_q[ch] <= '0;
                high_q[ch]   <= '0;
            end
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            missed_q <= missed_d;
            armed_q  <= armed_d;
            irq_q    <= irq_d;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch]    <= cnt_d[ch];
                hi_lat_q[ch] <= hi_lat_d[ch];
                period_q[ch] <= period_d[ch];
                high_q[ch]   <= high_d[ch];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_capture.sv
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Directed self-checking bench for pwm_capture (2 channels,
//                8-bit counters so saturation is reachable quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_capture;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic              PCLK = 1'b0;
    logic              PRESETN;
    logic [7:0]        PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [NUM_CH-1:0] pwm;
    logic              IRQ;

    int checks   = 0;
    int failures = 0;

    // PWM generator controls (written by the main sequence only)
    bit   gen_run   [NUM_CH];
    logic gen_level [NUM_CH];
    int   gen_per   [NUM_CH];
    int   gen_hi    [NUM_CH];
    int   gen_ph    [NUM_CH];

    pwm_capture #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_dut (
        .PCLK    (PCLK),
        .PRESETN (PRESETN),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .PWM_IN  (pwm),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    // Waveform source: high for gen_hi cycles out of every gen_per cycles
    always @(negedge PCLK) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (gen_run[c]) begin
                pwm[c] = (gen_ph[c] < gen_hi[c]);
                gen_ph[c] = (gen_ph[c] + 1 == gen_per[c]) ? 0 : gen_ph[c] + 1;
            end else begin
                pwm[c] = gen_level[c];
                gen_ph[c] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        v = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        check(tag, v, exp);
    endtask

    initial begin
        PRESETN = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0;
        PWRITE = 1'b0; PWDATA = '0; pwm = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gen_run[c] = 1'b0; gen_level[c] = 1'b0; gen_per[c] = 100; gen_hi[c] = 25;
        end
        cyc(3);
        PRESETN = 1'b1;
        cyc(2);

        // Reset values and idle bus
        rd_check("rst_ctrl",    8'h00, 32'h0);
        rd_check("rst_status",  8'h04, 32'h0);
        rd_check("rst_period0", 8'h10, 32'h0);
        rd_check("rst_high0",   8'h14, 32'h0);
        check("rst_irq", 32'(IRQ), 32'h0);
        check("pready",  32'(PREADY), 32'h1);
        check("pslverr", 32'(PSLVERR), 32'h0);
        PADDR = 8'h10;
        #1 check("prdata_idle", PRDATA, 32'h0);

        // Basic capture on ch0: period 100, high 25
        apb_write(8'h00, 32'h101);
        gen_per[0] = 100; gen_hi[0] = 25; gen_run[0] = 1'b1;
        cyc(60);
        rd_check("arm_only_status", 8'h04, 32'h0);
        cyc(60);
        rd_check("basic_period0", 8'h10, 32'd100);
        rd_check("basic_high0",   8'h14, 32'd25);
        rd_check("basic_status",  8'h04, 32'h1);
        check("basic_irq", 32'(IRQ), 32'h1);
        apb_write(8'h04, 32'h1);
        cyc(2);
        check("w1c_irq_drop", 32'(IRQ), 32'h0);
        rd_check("w1c_status", 8'h04, 32'h0);

        // Missed capture: VALID left set across two more periods
        cyc(206);
        rd_check("missed_status",  8'h04, 32'h0001_0001);
        rd_check("missed_period0", 8'h10, 32'd100);
        apb_write(8'h04, 32'h0001_0001);
        rd_check("missed_clear", 8'h04, 32'h0);

        // Disable ch0: results hold
        apb_write(8'h00, 32'h100);
        gen_run[0] = 1'b0; gen_level[0] = 1'b0;
        cyc(20);
        rd_check("dis_period0", 8'h10, 32'd100);
        rd_check("dis_high0",   8'h14, 32'd25);

        // Re-enable, first rise only arms; W1C lands on the capture edge
        apb_write(8'h00, 32'h101);
        cyc(5);
        gen_level[0] = 1'b1;
        cyc(10);
        gen_level[0] = 1'b0;
        rd_check("reen_arm_only", 8'h04, 32'h0);
        cyc(28);
        gen_level[0] = 1'b1;
        cyc(1);
        apb_write(8'h04, 32'h1);
        cyc(3);
        rd_check("race_valid",   8'h04, 32'h1);
        rd_check("race_period0", 8'h10, 32'd40);
        rd_check("race_high0",   8'h14, 32'd10);
        check("race_irq", 32'(IRQ), 32'h1);
        apb_write(8'h00, 32'h0);
        gen_level[0] = 1'b0;
        apb_write(8'h04, 32'hFFFF_FFFF);
        cyc(2);
        rd_check("clr_all", 8'h04, 32'h0);
        check("clr_irq", 32'(IRQ), 32'h0);

        // Saturation on ch1 (IRQ for ch1 not enabled)
        apb_write(8'h00, 32'h002);
        gen_per[1] = 60; gen_hi[1] = 20; gen_run[1] = 1'b1;
        cyc(150);
        gen_run[1] = 1'b0; gen_level[1] = 1'b0;
        rd_check("ch1_period", 8'h18, 32'd60);
        rd_check("ch1_high",   8'h1C, 32'd20);
        apb_write(8'h04, 32'hFFFF_FFFF);
        cyc(300);
        rd_check("sat_ovf",    8'h04, 32'h200);
        rd_check("sat_period", 8'h18, 32'd60);
        gen_level[1] = 1'b1;
        cyc(10);
        gen_level[1] = 1'b0;
        rd_check("sat_arm_only", 8'h04, 32'h200);
        cyc(38);
        gen_level[1] = 1'b1;
        cyc(6);
        rd_check("sat_recover_status", 8'h04, 32'h202);
        rd_check("sat_recover_period", 8'h18, 32'd50);
        rd_check("sat_recover_high",   8'h1C, 32'd10);
        check("irq_gated", 32'(IRQ), 32'h0);
        apb_write(8'h00, 32'h0);
        gen_level[1] = 1'b0;
        apb_write(8'h04, 32'hFFFF_FFFF);

        // Address decode
        rd_check("unmapped_rd", 8'h3C, 32'h0);
        apb_write(8'h3C, 32'hFFFF_FFFF);
        rd_check("unmapped_wr", 8'h3C, 32'h0);
        rd_check("unmapped_ctrl", 8'h00, 32'h0);
        rd_check("unmapped_08", 8'h08, 32'h0);
        rd_check("paddr_lsb", 8'h12, 32'd40);
        apb_write(8'h10, 32'h55);
        rd_check("ro_period", 8'h10, 32'd40);
        apb_write(8'h00, 32'hFFFF_FFFF);
        rd_check("ctrl_unused", 8'h00, 32'h303);
        apb_write(8'h00, 32'h0);
        apb_write(8'h04, 32'hFFFF_FFFF);

        // Reset in the middle of running capture
        apb_write(8'h00, 32'h101);
        gen_per[0] = 100; gen_hi[0] = 25; gen_run[0] = 1'b1;
        cyc(150);
        PRESETN = 1'b0;
        cyc(3);
        rd_check("midrst_ctrl",    8'h00, 32'h0);
        rd_check("midrst_status",  8'h04, 32'h0);
        rd_check("midrst_period0", 8'h10, 32'h0);
        rd_check("midrst_high0",   8'h14, 32'h0);
        check("midrst_irq", 32'(IRQ), 32'h0);
        PRESETN = 1'b1;
        gen_run[0] = 1'b0; gen_level[0] = 1'b0;
        cyc(5);
        apb_write(8'h00, 32'h101);
        gen_run[0] = 1'b1;
        cyc(50);
        rd_check("post_rst_arm", 8'h04, 32'h0);
        cyc(70);
        rd_check("post_rst_status",  8'h04, 32'h1);
        rd_check("post_rst_period0", 8'h10, 32'd100);
        check("post_rst_irq", 32'(IRQ), 32'h1);
        check("pready_end",  32'(PREADY), 32'h1);
        check("pslverr_end", 32'(PSLVERR), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
